// File: rtl/serial_transfer_register.sv
// Purpose : 26-bit parallel word <-> LSB-first serial stream, one odd-parity bit per 13-bit syllable, full duplex.
// Latency : LDACK 1 cycle after load accept; SO valid 1 cycle after arming BTS&PHS; RVLD 1 cycle after final BTS.
// Backpr. : LD is level-held by the requester and only accepted in IDLE; BTS/PHS are never stalled or dropped.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   bts, phs         bit-time strobe and phase-start marker (phs only meaningful with bts)
//   ld, pdata        load request (level) and word to transmit; ldack pulses after accept
//   busy             high whenever not IDLE
//   so, sov          registered serial out and its valid (SHIFT state)
//   si               serial in from arithmetic, sampled on each bts in SHIFT
//   rdata, perr      captured word and per-syllable parity error, updated with rvld
//   rvld, ferr       result-valid pulse, framing-error pulse
module serial_transfer_register (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bts,
    input  logic        phs,
    input  logic        ld,
    input  logic [25:0] pdata,
    output logic        ldack,
    output logic        busy,
    output logic        so,
    output logic        sov,
    input  logic        si,
    output logic [25:0] rdata,
    output logic [1:0]  perr,
    output logic        rvld,
    output logic        ferr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  k;          // bit-time counter within SHIFT, 0..27
    logic [27:0] tx;         // {P1, P0, word}: bit k is what SO carries at bit time k
    logic [27:0] rx;         // {RP1, RP0, word} as captured from SI
    logic [27:0] rx_full;    // rx with the bit being sampled on the final BTS merged in

    logic        accept;
    logic        arm;
    logic        last_bit;
    logic        frame_err;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        arm       = 1'b0;
        last_bit  = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (ld) begin
                    accept    = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (bts && phs) begin
                    arm       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bts) begin
                    // PHS at bit time 27 is just the next phase starting, not an error.
                    if (k == 5'd27) begin
                        last_bit  = 1'b1;
                        state_nxt = DONE;
                    end else if (phs) begin
                        frame_err = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign sov     = (state == SHIFT);
    assign rx_full = {si, rx[26:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            k     <= 5'd0;
            tx    <= 28'd0;
            rx    <= 28'd0;
            so    <= 1'b0;
            ldack <= 1'b0;
            rvld  <= 1'b0;
            ferr  <= 1'b0;
            rdata <= 26'd0;
            perr  <= 2'b00;
        end else begin
            state <= state_nxt;
            ldack <= accept;
            rvld  <= last_bit;
            ferr  <= frame_err;

            if (accept) begin
                // Parity bits make each syllable-plus-parity popcount odd.
                tx <= {~^pdata[25:13], ~^pdata[12:0], pdata};
            end

            if (arm) begin
                k  <= 5'd0;
                so <= tx[0];
            end

            if ((state == SHIFT) && bts && !frame_err) begin
                rx[k] <= si;
                k     <= k + 5'd1;
                so    <= last_bit ? 1'b0 : tx[k + 5'd1];
            end

            // Result is registered on the final BTS so that RDATA/PERR are already
            // valid during the DONE cycle, alongside RVLD.
            if (last_bit) begin
                k     <= 5'd0;
                rdata <= rx_full[25:0];
                perr  <= {~(^{rx_full[25:13], rx_full[27]}),
                          ~(^{rx_full[12:0],  rx_full[26]})};
            end

            if (frame_err) begin
                k  <= 5'd0;
                tx <= 28'd0;
                rx <= 28'd0;
                so <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_transfer_register.sv
module tb_serial_transfer_register;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bts;
    logic        phs;
    logic        ld;
    logic [25:0] pdata;
    logic        ldack;
    logic        busy;
    logic        so;
    logic        sov;
    logic        si;
    logic [25:0] rdata;
    logic [1:0]  perr;
    logic        rvld;
    logic        ferr;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [25:0] last_rdata;
    logic [1:0]  last_perr;

    serial_transfer_register dut (
        .clk   (clk),
        .rstn  (rstn),
        .bts   (bts),
        .phs   (phs),
        .ld    (ld),
        .pdata (pdata),
        .ldack (ldack),
        .busy  (busy),
        .so    (so),
        .sov   (sov),
        .si    (si),
        .rdata (rdata),
        .perr  (perr),
        .rvld  (rvld),
        .ferr  (ferr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit-time sequence of a word: 26 data bits LSB first, then P0, then P1,
    // where each parity bit brings its syllable's popcount to odd.
    function automatic logic [27:0] frame_of(input logic [25:0] w);
        logic p0;
        logic p1;
        p0 = ($countones(w[12:0])  % 2) == 0;
        p1 = ($countones(w[25:13]) % 2) == 0;
        return {p1, p0, w};
    endfunction

    // One transfer: load, arm, 28 bit times with SI = expected SO ^ inv.
    // ferr_at / rst_at >= 0 abort the transfer at that bit time.
    task automatic run_xfer(input logic [25:0] word, input logic [27:0] inv,
                            input int ferr_at, input int rst_at,
                            input bit hold, input logic [25:0] nxt);
        logic [27:0] fb;
        logic [27:0] rxb;
        int          gap;
        fb  = frame_of(word);
        rxb = fb ^ inv;

        // Load; a coincident BTS&PHS must not arm the fresh load.
        ld    = 1'b1;
        pdata = word;
        bts   = 1'($urandom_range(0, 1));
        phs   = bts;
        step();
        bts = 1'b0;
        phs = 1'b0;
        check("ldack_after_accept", 32'(ldack), 32'd1);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("sov_armed", 32'(sov), 32'd0);
        if (hold) begin
            pdata = nxt;
        end else begin
            ld    = 1'b0;
            pdata = 26'($urandom);
        end
        step();
        check("ldack_one_cycle", 32'(ldack), 32'd0);

        // BTS without PHS and PHS without BTS are both ignored while armed.
        repeat ($urandom_range(0, 3)) begin
            bts = 1'b1;
            step();
            bts = 1'b0;
            phs = 1'($urandom_range(0, 1));
            step();
            phs = 1'b0;
            check("armed_no_shift", 32'({sov, so}), 32'd0);
        end

        bts = 1'b1;
        phs = 1'b1;
        step();
        bts = 1'b0;
        phs = 1'b0;
        check("sov_on_arm", 32'(sov), 32'd1);
        check("so_bit0", 32'(so), 32'(fb[0]));

        for (int k = 0; k < 28; k++) begin
            if (k == rst_at) begin
                rstn = 1'b0;
                ld   = 1'b0;
                #1;
                check("rst_rdata", 32'(rdata), 32'd0);
                check("rst_ctl", 32'({so, sov, ldack, busy, rvld, ferr, perr}), 32'd0);
                step();
                check("rst_held", 32'({sov, busy, rvld, ferr}), 32'd0);
                rstn       = 1'b1;
                last_rdata = 26'd0;
                last_perr  = 2'b00;
                step();
                return;
            end
            gap = $urandom_range(0, 2);
            si  = rxb[k];
            repeat (gap) begin
                phs = 1'($urandom_range(0, 1));
                step();
                phs = 1'b0;
                check("so_stable", 32'({sov, so}), 32'({1'b1, fb[k]}));
                check("no_ldack_busy", 32'(ldack), 32'd0);
            end
            bts = 1'b1;
            if (k == ferr_at)  phs = 1'b1;
            else if (k == 27)  phs = 1'($urandom_range(0, 1));
            else               phs = 1'b0;
            step();
            bts = 1'b0;
            phs = 1'b0;
            si  = 1'($urandom_range(0, 1));
            if (k == ferr_at) begin
                check("ferr_pulse", 32'(ferr), 32'd1);
                check("ferr_ctl", 32'({rvld, busy, sov, so}), 32'd0);
                check("ferr_rdata_held", 32'(rdata), 32'(last_rdata));
                check("ferr_perr_held", 32'(perr), 32'(last_perr));
                step();
                check("ferr_one_cycle", 32'(ferr), 32'd0);
                return;
            end
            if (k < 27) begin
                check("so_bit", 32'({sov, so}), 32'({1'b1, fb[k+1]}));
                check("no_early_done", 32'({rvld, ferr, ldack}), 32'd0);
            end
        end

        last_rdata   = rxb[25:0];
        last_perr[0] = ($countones({rxb[26], rxb[12:0]})  % 2) == 0;
        last_perr[1] = ($countones({rxb[27], rxb[25:13]}) % 2) == 0;
        check("done_sov", 32'(sov), 32'd0);
        check("done_rvld", 32'(rvld), 32'd1);
        check("done_rdata", 32'(rdata), 32'(last_rdata));
        check("done_perr", 32'(perr), 32'(last_perr));
        check("done_busy_ldack", 32'({busy, ldack}), 32'({1'b1, 1'b0}));
        step();
        check("idle_busy_rvld", 32'({busy, rvld, ldack}), 32'd0);
        check("rdata_hold", 32'(rdata), 32'(last_rdata));
    endtask

    initial begin
        logic [25:0] w;
        rstn       = 1'b0;
        bts        = 1'b0;
        phs        = 1'b0;
        ld         = 1'b0;
        si         = 1'b0;
        pdata      = 26'd0;
        last_rdata = 26'd0;
        last_perr  = 2'b00;
        #1;
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_ctl", 32'({so, sov, ldack, busy, rvld, ferr, perr}), 32'd0);
        repeat (2) step();
        rstn = 1'b1;
        step();
        check("idle_after_reset", 32'({busy, sov, ldack}), 32'd0);

        run_xfer(26'h0000001, 28'd0, -1, -1, 1'b0, 26'd0);
        run_xfer(26'h3FFFFFF, 28'd0, -1, -1, 1'b0, 26'd0);
        run_xfer(26'h1555555, 28'h8000000, -1, -1, 1'b0, 26'd0);
        run_xfer(26'($urandom), 28'd0, 10, -1, 1'b0, 26'd0);
        run_xfer(26'h0ABCDEF, 28'd0, -1, -1, 1'b0, 26'd0);
        run_xfer(26'($urandom), 28'd0, -1, 5, 1'b0, 26'd0);
        run_xfer(26'h2AAAAAA, 28'd0, -1, -1, 1'b0, 26'd0);

        w = 26'($urandom);
        run_xfer(26'h1234567, 28'd0, -1, -1, 1'b1, w);
        run_xfer(w, 28'h0000400, -1, -1, 1'b0, 26'd0);

        for (int i = 0; i < 10; i++) begin
            run_xfer(26'($urandom), 28'($urandom) & 28'($urandom) & 28'($urandom),
                     (i % 4 == 3) ? $urandom_range(0, 26) : -1, -1, 1'b0, 26'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
